// File: rtl/dtc_trig_decoder.sv
// dtc_trig_decoder: FEE-side deframer/decoder for the serial DTC trigger line.
// Define DTC_TRIG_SEQCHK_EN to add the L0/L1/L2 ordering and time-window check.
module dtc_trig_decoder #(
    parameter logic [15:0] L1_TW_MAX = 16'd300,
    parameter logic [15:0] L2_TW_MAX = 16'd20000
) (
    input  logic        dtc_clk,
    input  logic        reset,
    input  logic        trig_in,
    output logic        l0_pulse,
    output logic        l1_pulse,
    output logic        l2a_pulse,
    output logic        l2r_pulse,
    output logic        evcnt_rst_pulse,
    output logic [11:0] trig_payload,
    output logic [23:0] ev_cnt,
    output logic        parity_err,
    output logic        type_err,
    output logic [15:0] err_cnt,
    output logic        seq_err,
    output logic        trig_busy
);

    typedef enum logic [1:0] {D_ARM, D_IDLE, D_SHIFT} dstate_t;

    dstate_t     dstate;
    dstate_t     dstate_nxt;
    logic [4:0]  bcnt;
    logic [16:0] sr;
    logic        frame_done;

    always_ff @(posedge dtc_clk) begin
        if (reset) dstate <= D_ARM;
        else       dstate <= dstate_nxt;
    end

    // ARM keeps a line stuck high after reset from looking like a start bit
    always_comb begin
        dstate_nxt = dstate;
        unique case (dstate)
            D_ARM:   if (!trig_in) dstate_nxt = D_IDLE;
            D_IDLE:  if (trig_in) dstate_nxt = D_SHIFT;
            D_SHIFT: if (bcnt == 5'd17) dstate_nxt = D_IDLE;
            default: dstate_nxt = D_ARM;
        endcase
    end

    always_ff @(posedge dtc_clk) begin
        if (reset) begin
            bcnt       <= '0;
            sr         <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (dstate == D_IDLE && trig_in) begin
                bcnt <= 5'd1;
            end else if (dstate == D_SHIFT) begin
                sr         <= {sr[15:0], trig_in};
                bcnt       <= bcnt + 5'd1;
                frame_done <= (bcnt == 5'd17);
            end
        end
    end

    logic [3:0]  ftype;
    logic [11:0] fpay;
    logic        par_ok;
    logic        good;
    logic        is_def;
    logic        is_l0;
    logic        is_l1;
    logic        is_l2a;
    logic        is_l2r;
    logic        is_evr;
    logic        bad;

    assign ftype  = sr[16:13];
    assign fpay   = sr[12:1];
    assign par_ok = ~^sr;
    assign good   = frame_done & par_ok;
    assign is_l0  = good & (ftype == 4'h1);
    assign is_l1  = good & (ftype == 4'h2);
    assign is_l2a = good & (ftype == 4'h3);
    assign is_l2r = good & (ftype == 4'h4);
    assign is_evr = good & (ftype == 4'h8);
    assign is_def = is_l0 | is_l1 | is_l2a | is_l2r | is_evr;
    assign bad    = frame_done & ~is_def;

    always_ff @(posedge dtc_clk) begin
        if (reset) begin
            l0_pulse        <= 1'b0;
            l1_pulse        <= 1'b0;
            l2a_pulse       <= 1'b0;
            l2r_pulse       <= 1'b0;
            evcnt_rst_pulse <= 1'b0;
            parity_err      <= 1'b0;
            type_err        <= 1'b0;
            trig_payload    <= '0;
            ev_cnt          <= '0;
            err_cnt         <= '0;
        end else begin
            l0_pulse        <= is_l0;
            l1_pulse        <= is_l1;
            l2a_pulse       <= is_l2a;
            l2r_pulse       <= is_l2r;
            evcnt_rst_pulse <= is_evr;
            parity_err      <= frame_done & ~par_ok;
            type_err        <= good & ~is_def;
            if (is_def) trig_payload <= fpay;
            if (is_evr)      ev_cnt <= '0;
            else if (is_l2a) ev_cnt <= ev_cnt + 24'd1;
            if (bad && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        end
    end

`ifdef DTC_TRIG_SEQCHK_EN
    typedef enum logic [1:0] {S_IDLE, S_WAIT_L1, S_WAIT_L2} sstate_t;

    sstate_t     sstate;
    sstate_t     sstate_nxt;
    logic [15:0] tcnt;
    logic [15:0] tcnt_nxt;
    logic        seq_err_nxt;

    always_ff @(posedge dtc_clk) begin
        if (reset) begin
            sstate  <= S_IDLE;
            tcnt    <= '0;
            seq_err <= 1'b0;
        end else begin
            sstate  <= sstate_nxt;
            tcnt    <= tcnt_nxt;
            seq_err <= seq_err_nxt;
        end
    end

    // a trigger landing on the window's last cycle wins over the timeout
    always_comb begin
        sstate_nxt  = sstate;
        seq_err_nxt = 1'b0;
        tcnt_nxt    = (sstate == S_IDLE) ? 16'd0 : tcnt + 16'd1;
        if (sstate == S_WAIT_L1 && tcnt_nxt == L1_TW_MAX) begin
            sstate_nxt = S_IDLE;
        end
        if (sstate == S_WAIT_L2 && tcnt_nxt == L2_TW_MAX) begin
            sstate_nxt  = S_IDLE;
            seq_err_nxt = 1'b1;
        end
        if (is_l0) begin
            sstate_nxt = S_WAIT_L1;
            tcnt_nxt   = '0;
        end else if (is_l1) begin
            if (sstate == S_WAIT_L1) begin
                sstate_nxt = S_WAIT_L2;
                tcnt_nxt   = '0;
            end else begin
                seq_err_nxt = 1'b1;
            end
        end else if (is_l2a || is_l2r) begin
            if (sstate == S_WAIT_L2) begin
                sstate_nxt  = S_IDLE;
                seq_err_nxt = 1'b0;
            end else begin
                seq_err_nxt = 1'b1;
            end
        end
    end

    assign trig_busy = (sstate != S_IDLE);
`else
    logic unused_tw;
    assign unused_tw = ^{L1_TW_MAX, L2_TW_MAX};
    assign seq_err   = 1'b0;
    assign trig_busy = 1'b0;
`endif

endmodule

// File: tb/tb_dtc_trig_decoder.sv
// Bench for dtc_trig_decoder: directed scenarios plus randomized frame streams
// compared with a protocol-level model (counters, payload, trigger phase).
`timescale 1ns/1ps
module tb_dtc_trig_decoder;

`ifdef DTC_TRIG_SEQCHK_EN
    localparam bit SEQ = 1'b1;
`else
    localparam bit SEQ = 1'b0;
`endif
    localparam int L1W = 300;
    localparam int L2W = 20000;

    logic        dtc_clk = 1'b0;
    logic        reset   = 1'b1;
    logic        trig_in = 1'b0;
    logic        l0_pulse, l1_pulse, l2a_pulse, l2r_pulse, evcnt_rst_pulse;
    logic [11:0] trig_payload;
    logic [23:0] ev_cnt;
    logic        parity_err, type_err, seq_err, trig_busy;
    logic [15:0] err_cnt;

    dtc_trig_decoder dut (
        .dtc_clk         (dtc_clk),
        .reset           (reset),
        .trig_in         (trig_in),
        .l0_pulse        (l0_pulse),
        .l1_pulse        (l1_pulse),
        .l2a_pulse       (l2a_pulse),
        .l2r_pulse       (l2r_pulse),
        .evcnt_rst_pulse (evcnt_rst_pulse),
        .trig_payload    (trig_payload),
        .ev_cnt          (ev_cnt),
        .parity_err      (parity_err),
        .type_err        (type_err),
        .err_cnt         (err_cnt),
        .seq_err         (seq_err),
        .trig_busy       (trig_busy)
    );

    always #4 dtc_clk = ~dtc_clk;

    int cyc = 0;
    always @(posedge dtc_clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // snapshot of outputs on a chosen cycle; strobe order l0,l1,l2a,l2r,evr,perr,terr,seq
    logic [7:0]  s_str;
    logic        s_busy;
    logic [11:0] s_pay;
    logic [23:0] s_ev;
    logic [15:0] s_err;
    int          s_cyc;
    int          stray;
    int          busy_lo;

    // protocol model state
    logic [23:0] m_ev;
    int          m_err;
    logic [11:0] m_pay;
    int          m_phase;
    int          m_t;

    function automatic logic [7:0] strb();
        return {l0_pulse, l1_pulse, l2a_pulse, l2r_pulse,
                evcnt_rst_pulse, parity_err, type_err, seq_err};
    endfunction

    function automatic logic [17:0] mk(input logic [3:0] t,
                                       input logic [11:0] p,
                                       input bit flip);
        logic par;
        par = (^{t, p}) ^ flip;
        return {1'b1, t, p, par};
    endfunction

    task automatic tick(input logic b, input bit snap);
        trig_in = b;
        @(posedge dtc_clk);
        #1;
        if (snap) begin
            s_str  = strb();
            s_busy = trig_busy;
            s_pay  = trig_payload;
            s_ev   = ev_cnt;
            s_err  = err_cnt;
            s_cyc  = cyc;
        end else if (strb() != 8'h00) begin
            stray++;
        end
        if (!trig_busy) busy_lo++;
    endtask

    task automatic drive_frame(input logic [17:0] f, input bit snap);
        for (int i = 0; i < 18; i++) tick(f[17-i], snap && i == 0);
    endtask

    task automatic drive_idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, i == 0);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        trig_in = 1'b0;
        repeat (3) @(posedge dtc_clk);
        #1;
        reset = 1'b0;
        tick(1'b0, 1'b0);
    endtask

    task automatic model(input logic [3:0] t, input logic [11:0] p,
                         input bit flip, input int c,
                         output logic [7:0] es, output bit eb);
        es = 8'h00;
        if (SEQ) begin
            if (m_phase == 1 && c - m_t > L1W) m_phase = 0;
            if (m_phase == 2 && c - m_t > L2W) m_phase = 0;
        end
        if (flip) begin
            es[2] = 1'b1;
            if (m_err < 65535) m_err++;
        end else begin
            case (t)
                4'h1: begin
                    es[7] = 1'b1; m_pay = p;
                    m_phase = 1; m_t = c;
                end
                4'h2: begin
                    es[6] = 1'b1; m_pay = p;
                    if (m_phase == 1) begin m_phase = 2; m_t = c; end
                    else es[0] = SEQ;
                end
                4'h3, 4'h4: begin
                    if (t == 4'h3) begin es[5] = 1'b1; m_ev = m_ev + 24'd1; end
                    else es[4] = 1'b1;
                    m_pay = p;
                    if (m_phase == 2) m_phase = 0;
                    else es[0] = SEQ;
                end
                4'h8: begin
                    es[3] = 1'b1; m_pay = p; m_ev = '0;
                end
                default: begin
                    es[1] = 1'b1;
                    if (m_err < 65535) m_err++;
                end
            endcase
        end
        eb = SEQ && (m_phase != 0);
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        trig_in = 1'b1;
        repeat (3) @(posedge dtc_clk);
        #1;
        tests++;
        if ({strb(), trig_busy, trig_payload, ev_cnt, err_cnt} !== '0) begin
            fails++;
            $display("FAIL reset_values: got str=%h pay=%h ev=%h err=%h, want all 0",
                     strb(), trig_payload, ev_cnt, err_cnt);
        end
        reset = 1'b0;
        stray = 0;
        for (int i = 0; i < 40; i++) tick(1'b1, 1'b0);
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b0);
        tests++;
        if (stray !== 0) begin
            fails++;
            $display("FAIL stuck_high: got %0d strobe cycles, want 0", stray);
        end
    endtask

    task automatic test_l0();
        stray = 0;
        drive_frame(mk(4'h1, 12'h0A5, 1'b0), 1'b0);
        drive_idle(2);
        tests++;
        if (s_str !== 8'h80 || s_pay !== 12'h0A5) begin
            fails++;
            $display("FAIL l0_frame: got str=%h pay=%h, want str=80 pay=0a5", s_str, s_pay);
        end
        tests++;
        if (stray !== 0) begin
            fails++;
            $display("FAIL l0_single: got %0d extra strobe cycles, want 0", stray);
        end
    endtask

    task automatic test_back_to_back();
        drive_frame(mk(4'h1, 12'h111, 1'b0), 1'b0);
        busy_lo = 0;
        stray   = 0;
        drive_frame(mk(4'h2, 12'h222, 1'b0), 1'b1);
        tests++;
        if (s_str !== 8'h80 || s_pay !== 12'h111) begin
            fails++;
            $display("FAIL b2b_l0: got str=%h pay=%h, want str=80 pay=111", s_str, s_pay);
        end
        drive_frame(mk(4'h3, 12'h333, 1'b0), 1'b1);
        tests++;
        if (s_str !== 8'h40 || s_pay !== 12'h222 || s_ev !== 24'd0) begin
            fails++;
            $display("FAIL b2b_l1: got str=%h pay=%h ev=%h, want str=40 pay=222 ev=0",
                     s_str, s_pay, s_ev);
        end
        tests++;
        if (busy_lo !== (SEQ ? 0 : 36)) begin
            fails++;
            $display("FAIL b2b_busy: got %0d idle cycles, want %0d", busy_lo, SEQ ? 0 : 36);
        end
        drive_idle(1);
        tests++;
        if (s_str !== 8'h20 || s_ev !== 24'd1 || s_busy !== 1'b0 || s_pay !== 12'h333) begin
            fails++;
            $display("FAIL b2b_l2a: got str=%h ev=%h busy=%b pay=%h, want str=20 ev=1 busy=0 pay=333",
                     s_str, s_ev, s_busy, s_pay);
        end
        tests++;
        if (stray !== 0) begin
            fails++;
            $display("FAIL b2b_stray: got %0d stray strobe cycles, want 0", stray);
        end
    endtask

    task automatic test_errors();
        drive_frame(mk(4'h3, 12'h444, 1'b1), 1'b0);
        drive_idle(1);
        tests++;
        if (s_str !== 8'h04 || s_err !== 16'd1 || s_ev !== 24'd1 || s_pay !== 12'h333) begin
            fails++;
            $display("FAIL parity: got str=%h err=%h ev=%h pay=%h, want str=04 err=1 ev=1 pay=333",
                     s_str, s_err, s_ev, s_pay);
        end
        drive_frame(mk(4'h6, 12'h555, 1'b0), 1'b0);
        drive_idle(1);
        tests++;
        if (s_str !== 8'h02 || s_err !== 16'd2 || s_ev !== 24'd1 || s_pay !== 12'h333) begin
            fails++;
            $display("FAIL type: got str=%h err=%h ev=%h pay=%h, want str=02 err=2 ev=1 pay=333",
                     s_str, s_err, s_ev, s_pay);
        end
    endtask

    task automatic test_timeout();
        int  nseq;
        int  first;
        bit  b_before;
        bit  b_at;
        nseq  = 0;
        first = -1;
        b_before = 1'b0;
        b_at     = 1'b1;
        drive_frame(mk(4'h1, 12'h010, 1'b0), 1'b0);
        drive_frame(mk(4'h2, 12'h020, 1'b0), 1'b0);
        trig_in = 1'b0;
        for (int k = 0; k < L2W + 50; k++) begin
            @(posedge dtc_clk);
            #1;
            if (k == 0) begin
                tests++;
                if (l1_pulse !== 1'b1) begin
                    fails++;
                    $display("FAIL tmo_l1: got l1_pulse=%b, want 1", l1_pulse);
                end
            end
            if (seq_err === 1'b1) begin
                nseq++;
                if (first < 0) first = k;
            end
            if (k == L2W - 1) b_before = trig_busy;
            if (k == L2W) b_at = trig_busy;
        end
        tests++;
        if (nseq !== (SEQ ? 1 : 0) || first !== (SEQ ? L2W : -1)) begin
            fails++;
            $display("FAIL tmo_seq: got %0d pulses first at %0d, want %0d at %0d",
                     nseq, first, SEQ ? 1 : 0, SEQ ? L2W : -1);
        end
        tests++;
        if ({b_before, b_at} !== (SEQ ? 2'b10 : 2'b00)) begin
            fails++;
            $display("FAIL tmo_busy: got %b%b, want %b", b_before, b_at, SEQ ? 2'b10 : 2'b00);
        end
        drive_frame(mk(4'h2, 12'h666, 1'b0), 1'b0);
        drive_idle(1);
        tests++;
        if (s_str !== (SEQ ? 8'h41 : 8'h40)) begin
            fails++;
            $display("FAIL l1_no_l0: got str=%h, want %h", s_str, SEQ ? 8'h41 : 8'h40);
        end
    endtask

    task automatic test_wrap();
        logic [23:0] want;
        force dut.ev_cnt = 24'hFFFFFF;
        @(posedge dtc_clk);
        #1;
        release dut.ev_cnt;
        drive_idle(1);
        tests++;
        if (s_ev !== 24'hFFFFFF) begin
            fails++;
            $display("FAIL preload: got ev=%h, want ffffff", s_ev);
        end
        drive_frame(mk(4'h3, 12'h777, 1'b0), 1'b0);
        drive_idle(1);
        tests++;
        if (s_str !== (SEQ ? 8'h21 : 8'h20) || s_ev !== 24'd0) begin
            fails++;
            $display("FAIL wrap: got str=%h ev=%h, want str=%h ev=0",
                     s_str, s_ev, SEQ ? 8'h21 : 8'h20);
        end
        drive_frame(mk(4'h3, 12'h001, 1'b0), 1'b0);
        for (int i = 1; i <= 3; i++) begin
            if (i < 3) drive_frame(mk(4'h3, 12'h001, 1'b0), 1'b1);
            else drive_frame(mk(4'h8, 12'h9AB, 1'b0), 1'b1);
            want = 24'(i);
            tests++;
            if (s_ev !== want) begin
                fails++;
                $display("FAIL l2a_count: got ev=%h, want %h", s_ev, want);
            end
        end
        drive_idle(1);
        tests++;
        if (s_str !== 8'h08 || s_ev !== 24'd0 || s_pay !== 12'h9AB) begin
            fails++;
            $display("FAIL evcnt_rst: got str=%h ev=%h pay=%h, want str=08 ev=0 pay=9ab",
                     s_str, s_ev, s_pay);
        end
    endtask

    task automatic test_reset_mid();
        logic [17:0] f;
        f = mk(4'h1, 12'h0FF, 1'b0);
        for (int i = 0; i < 9; i++) tick(f[17-i], 1'b0);
        reset = 1'b1;
        tick(f[8], 1'b0);
        reset = 1'b0;
        stray = 0;
        for (int i = 0; i < 25; i++) tick(1'b0, 1'b0);
        tests++;
        if (stray !== 0 || {trig_payload, ev_cnt, err_cnt} !== '0) begin
            fails++;
            $display("FAIL reset_mid: got %0d strobe cycles pay=%h ev=%h err=%h, want 0",
                     stray, trig_payload, ev_cnt, err_cnt);
        end
        drive_frame(mk(4'h1, 12'h123, 1'b0), 1'b0);
        drive_idle(1);
        tests++;
        if (s_str !== 8'h80 || s_pay !== 12'h123) begin
            fails++;
            $display("FAIL after_reset: got str=%h pay=%h, want str=80 pay=123", s_str, s_pay);
        end
    endtask

    task automatic test_random();
        logic [3:0]  ctype, ptype;
        logic [11:0] cpay, ppay;
        bit          cflip, pflip;
        int          gap;
        logic [7:0]  es;
        bit          eb;
        logic [3:0]  kinds [6];
        kinds = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h8, 4'h1};
        do_reset();
        m_ev = '0; m_err = 0; m_pay = '0; m_phase = 0; m_t = 0;
        stray = 0;
        ptype = '0; ppay = '0; pflip = 1'b0;
        for (int i = 0; i <= 80; i++) begin
            ctype = '0; cpay = '0; cflip = 1'b0;
            gap   = 1;
            if (i < 80) begin
                if ($urandom_range(0, 4) == 0) ctype = 4'($urandom_range(0, 15));
                else ctype = kinds[$urandom_range(0, 5)];
                cpay  = 12'($urandom);
                cflip = ($urandom_range(0, 7) == 0);
                gap   = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
            end
            if (gap > 0) drive_idle(gap);
            if (i < 80) drive_frame(mk(ctype, cpay, cflip), gap == 0);
            if (i > 0) begin
                model(ptype, ppay, pflip, s_cyc, es, eb);
                tests++;
                if (s_str !== es || s_busy !== eb) begin
                    fails++;
                    $display("FAIL rnd_strobe[%0d]: got str=%h busy=%b, want str=%h busy=%b",
                             i - 1, s_str, s_busy, es, eb);
                end
                tests++;
                if (s_pay !== m_pay || s_ev !== m_ev || s_err !== 16'(m_err)) begin
                    fails++;
                    $display("FAIL rnd_regs[%0d]: got pay=%h ev=%h err=%h, want pay=%h ev=%h err=%h",
                             i - 1, s_pay, s_ev, s_err, m_pay, m_ev, 16'(m_err));
                end
            end
            ptype = ctype; ppay = cpay; pflip = cflip;
        end
        tests++;
        if (stray !== 0) begin
            fails++;
            $display("FAIL rnd_stray: got %0d unexpected strobe cycles, want 0", stray);
        end
    endtask

    initial begin
        test_reset();
        test_l0();
        test_back_to_back();
        test_errors();
        test_timeout();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
